// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, ACK encoding and R/W bit layout.
// Also used by i2c_master so both sides agree on the address byte format.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_MACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;
  localparam int   BYTE_SIZE = 8;

  // R/W flag sits in the LSB of the address byte
  localparam int   RW_BIT    = 0;
  localparam logic RW_WRITE  = 1'b0;
  localparam logic RW_READ   = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Oversamples SCL/SDA into clk: 2-FF synchronizers plus one delayed copy,
// producing SCL edge strobes and START/STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0],[1] synchronizer stages, [2] previous synchronized value
  logic [2:0] scl_pipe_reg;
  logic [2:0] sda_pipe_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_pipe_reg <= 3'b111;
      sda_pipe_reg <= 3'b111;
    end else begin
      scl_pipe_reg <= {scl_pipe_reg[1:0], scl_in};
      sda_pipe_reg <= {sda_pipe_reg[1:0], sda_in};
    end
  end

  assign scl_rise  =  scl_pipe_reg[1] & ~scl_pipe_reg[2];
  assign scl_fall  = ~scl_pipe_reg[1] &  scl_pipe_reg[2];
  assign start_det =  scl_pipe_reg[1] &  scl_pipe_reg[2] &  sda_pipe_reg[2] & ~sda_pipe_reg[1];
  assign stop_det  =  scl_pipe_reg[1] &  scl_pipe_reg[2] & ~sda_pipe_reg[2] &  sda_pipe_reg[1];
  assign sda_s     =  sda_pipe_reg[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address, fixed NUM_BYTE-byte writes presented as one word.
// Define I2C_SLAVE_READ_EN to add fixed-length reads from rddata.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter int         NUM_BYTE   = 2,
  parameter int         BYTE_SIZE  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  inout  wire                             i2c_SCL,
  inout  wire                             i2c_SDA,
  output logic [NUM_BYTE*BYTE_SIZE-1:0]   wrdata,
  output logic                            wr_vld,
  input  logic [NUM_BYTE*BYTE_SIZE-1:0]   rddata,
  output logic                            rd_req,
  output logic                            busy
);
  import i2c_pkg::*;

  localparam int W  = NUM_BYTE * BYTE_SIZE;
  localparam int CW = $clog2(NUM_BYTE + 1);

`ifdef I2C_SLAVE_READ_EN
  localparam logic READ_EN = 1'b1;
`else
  localparam logic READ_EN = 1'b0;
`endif

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_state_t           state_reg;
  logic [3:0]           bit_cnt_reg;
  logic [CW-1:0]        byte_cnt_reg;
  logic [BYTE_SIZE-2:0] shift_reg;
  logic [W-1:0]         stage_reg;
  logic [W-1:0]         rshift_reg;
  logic [W-1:0]         wrdata_reg;
  logic                 wr_vld_reg, rd_req_reg, busy_reg, sda_oe_reg, rw_reg;
  logic [BYTE_SIZE-1:0] byte_in;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (i2c_SCL),
    .sda_in    (i2c_SDA),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign byte_in = {shift_reg, sda_s};
  assign i2c_SDA = sda_oe_reg ? 1'b0 : 1'bz;
  assign wrdata  = wrdata_reg;
  assign wr_vld  = wr_vld_reg;
  assign rd_req  = rd_req_reg;
  assign busy    = busy_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
      stage_reg    <= '0;
      rshift_reg   <= '0;
      wrdata_reg   <= '0;
      wr_vld_reg   <= 1'b0;
      rd_req_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      sda_oe_reg   <= 1'b0;
      rw_reg       <= RW_WRITE;
    end else begin
      wr_vld_reg <= 1'b0;
      rd_req_reg <= 1'b0;
      if (start_det || stop_det) begin
        // bus conditions override whatever bit-level work was in progress
        state_reg    <= start_det ? ADDR : IDLE;
        bit_cnt_reg  <= '0;
        byte_cnt_reg <= '0;
        sda_oe_reg   <= 1'b0;
        busy_reg     <= 1'b0;
      end else begin
        case (state_reg)
          ADDR: if (scl_rise) begin
            shift_reg   <= byte_in[BYTE_SIZE-2:0];
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'(BYTE_SIZE - 1)) begin
              rw_reg <= byte_in[RW_BIT];
              if (byte_in[BYTE_SIZE-1:1] == SLAVE_ADDR &&
                  (byte_in[RW_BIT] == RW_WRITE || READ_EN)) begin
                state_reg <= ADDR_ACK;
                busy_reg  <= 1'b1;
              end else begin
                state_reg <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_reg <= (ACK == 1'b0);
              if (rw_reg == RW_READ) begin
                rd_req_reg <= 1'b1;
                rshift_reg <= rddata;
              end
            end else if (rw_reg == RW_READ) begin
              // the falling edge that ends the ACK slot also launches read bit 7
              sda_oe_reg  <= ~rshift_reg[W-1];
              rshift_reg  <= rshift_reg << 1;
              bit_cnt_reg <= 4'd1;
              state_reg   <= RDATA;
            end else begin
              sda_oe_reg  <= 1'b0;
              bit_cnt_reg <= '0;
              state_reg   <= WDATA;
            end
          end
          WDATA: if (scl_rise) begin
            shift_reg   <= byte_in[BYTE_SIZE-2:0];
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'(BYTE_SIZE - 1)) begin
              stage_reg    <= (stage_reg << BYTE_SIZE) | W'(byte_in);
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
              state_reg    <= WDATA_ACK;
            end
          end
          WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_reg <= (ACK == 1'b0);
            end else begin
              sda_oe_reg  <= 1'b0;
              bit_cnt_reg <= '0;
              if (byte_cnt_reg == CW'(NUM_BYTE)) begin
                wrdata_reg <= stage_reg;
                wr_vld_reg <= 1'b1;
                state_reg  <= WAIT_STOP;
              end else begin
                state_reg  <= WDATA;
              end
            end
          end
          RDATA: if (scl_fall) begin
            if (bit_cnt_reg == 4'(BYTE_SIZE)) begin
              sda_oe_reg <= 1'b0;
              state_reg  <= RDATA_MACK;
            end else begin
              sda_oe_reg  <= ~rshift_reg[W-1];
              rshift_reg  <= rshift_reg << 1;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
          RDATA_MACK: if (scl_rise) begin
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
            bit_cnt_reg  <= '0;
            if (sda_s == ACK && byte_cnt_reg < CW'(NUM_BYTE - 1))
              state_reg <= RDATA;
            else
              state_reg <= WAIT_STOP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged controller, transaction-level
// model of expected ACKs and write words, per-cycle output compare.
module tb_i2c_slave;
  localparam int Q  = 10;
  localparam int NB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl_drv = 1'b1;
  logic        sda_low = 1'b0;
  wire         scl;
  wire         sda;
  logic [15:0] wrdata;
  logic [15:0] rddata = 16'hBEEF;
  logic        wr_vld, rd_req, busy;

  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_pulses = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_hold = 16'h0000;

  assign scl = scl_drv;
  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk     (clk),
    .rst     (rst),
    .i2c_SCL (scl),
    .i2c_SDA (sda),
    .wrdata  (wrdata),
    .wr_vld  (wr_vld),
    .rddata  (rddata),
    .rd_req  (rd_req),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare: wrdata holds the model word except on wr_vld,
  // where it must equal the next word the model queued.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_vld) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected wr_vld: wrdata %h, no write expected", wrdata);
        end else begin
          model_hold = exp_q.pop_front();
          check("wrdata at wr_vld", {16'h0, wrdata}, {16'h0, model_hold});
        end
      end else begin
        check("wrdata hold", {16'h0, wrdata}, {16'h0, model_hold});
      end
`ifdef I2C_SLAVE_READ_EN
      if (rd_req) rd_pulses++;
`else
      check("rd_req tied low", {31'h0, rd_req}, 32'h0);
`endif
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_low = 1'b0; clks(Q);
    scl_drv = 1'b1; clks(Q);
    sda_low = 1'b1; clks(Q);
    scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    clks(Q); sda_low = 1'b1;
    clks(Q); scl_drv = 1'b1;
    clks(Q); sda_low = 1'b0;
    clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      clks(Q); sda_low = ~b[i];
      clks(Q); scl_drv = 1'b1;
      clks(2*Q); scl_drv = 1'b0;
    end
  endtask

  task automatic ack_slot(output logic s, output logic bsy);
    clks(Q); sda_low = 1'b0;
    clks(Q); scl_drv = 1'b1;
    clks(Q); s = sda; bsy = busy;
    clks(Q); scl_drv = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      clks(Q); sda_low = 1'b0;
      clks(Q); scl_drv = 1'b1;
      clks(Q); v[i] = sda;
      clks(Q); scl_drv = 1'b0;
    end
  endtask

  task automatic master_ack(input logic nack);
    clks(Q); sda_low = ~nack;
    clks(Q); scl_drv = 1'b1;
    clks(2*Q); scl_drv = 1'b0;
  endtask

  // Model: the target ACKs its own write address and the first NB data
  // bytes; a write with at least NB bytes yields {byte0, byte1}.
  task automatic write_txn(input string tag, input logic [7:0] a,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input int n);
    logic [7:0] d [3];
    logic       s, bsy;
    bit         a_ok;
    d[0] = d0; d[1] = d1; d[2] = d2;
    a_ok = (a[7:1] == 7'h1A) && (a[0] == 1'b0);
    if (a_ok && n >= NB) exp_q.push_back({d[0], d[1]});
    bus_start();
    send_byte(a);
    ack_slot(s, bsy);
    check({tag, " addr ack"}, {31'h0, s}, a_ok ? 32'h0 : 32'h1);
    check({tag, " busy after addr"}, {31'h0, bsy}, {31'h0, a_ok});
    for (int i = 0; i < n; i++) begin
      send_byte(d[i]);
      ack_slot(s, bsy);
      check({tag, " data ack"}, {31'h0, s}, (a_ok && i < NB) ? 32'h0 : 32'h1);
      if (a_ok && i == NB - 1) begin
        clks(5);
        check({tag, " wr_vld latency"}, exp_q.size(), 32'h0);
      end
    end
    bus_stop();
    check({tag, " busy after stop"}, {31'h0, busy}, 32'h0);
    $display("txn %s: addr=%h bytes=%0d wrdata=%h", tag, a, n, wrdata);
  endtask

  initial begin
    logic       s, bsy;
    logic [7:0] v;

    clks(3);
    check("reset wrdata", {16'h0, wrdata}, 32'h0);
    check("reset wr_vld", {31'h0, wr_vld}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset sda released", {31'h0, sda}, 32'h1);
    check("reset rd_req", {31'h0, rd_req}, 32'h0);
    rst = 1'b1;
    clks(5);

    write_txn("t1 write 1E00", 8'h34, 8'h1E, 8'h00, 8'h00, 2);
    check("t1 wrdata", {16'h0, wrdata}, 32'h1E00);

    write_txn("t2 wrong addr", 8'h36, 8'h00, 8'h00, 8'h00, 0);
    check("t2 wrdata kept", {16'h0, wrdata}, 32'h1E00);

    write_txn("t3 short write", 8'h34, 8'h12, 8'h00, 8'h00, 1);
    check("t3 wrdata kept", {16'h0, wrdata}, 32'h1E00);

    write_txn("t4 long write", 8'h34, 8'hAB, 8'hCD, 8'hEF, 3);
    check("t4 wrdata", {16'h0, wrdata}, 32'hABCD);

    // reset while the target is driving an ACK low
    bus_start();
    send_byte(8'h34);
    ack_slot(s, bsy);
    check("t5 addr ack", {31'h0, s}, 32'h0);
    send_byte(8'h55);
    clks(Q);
    check("t5 ack driven before reset", {31'h0, sda}, 32'h0);
    rst = 1'b0;
    model_hold = 16'h0000;
    #1;
    check("t5 sda released by reset", {31'h0, sda}, 32'h1);
    check("t5 busy cleared by reset", {31'h0, busy}, 32'h0);
    check("t5 wrdata cleared by reset", {16'h0, wrdata}, 32'h0);
    $display("txn t5 reset mid-transaction: sda=%b busy=%b", sda, busy);
    clks(3);
    rst = 1'b1;
    clks(Q);
    write_txn("t5 write after reset", 8'h34, 8'h0C, 8'h9F, 8'h00, 2);
    check("t5 wrdata", {16'h0, wrdata}, 32'h0C9F);

`ifdef I2C_SLAVE_READ_EN
    bus_start();
    send_byte(8'h35);
    ack_slot(s, bsy);
    check("t6 read addr ack", {31'h0, s}, 32'h0);
    check("t6 busy after addr", {31'h0, bsy}, 32'h1);
    read_byte(v);
    check("t6 read byte 0", {24'h0, v}, 32'hBE);
    master_ack(1'b0);
    read_byte(v);
    check("t6 read byte 1", {24'h0, v}, 32'hEF);
    master_ack(1'b1);
    bus_stop();
    check("t6 rd_req pulses", rd_pulses, 32'h1);
    check("t6 busy after stop", {31'h0, busy}, 32'h0);
    $display("txn t6 read: rd_req pulses=%0d", rd_pulses);
`endif

    clks(Q);
    check("no pending writes", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
